// File: rtl/refill_sched_pkg.sv
// rtl/refill_sched_pkg.sv - shared configuration, table entry type and drain states for refill_sched
package refill_sched_pkg;

    // Width of the line id carried inside a table entry.
    localparam int unsigned NlineWidth = 8;

    typedef logic [NlineWidth-1:0] nline_t;

    typedef struct packed {
        int unsigned rfbufSize;
        int unsigned mshrNum;
        int unsigned starveLimit;
    } mpc_cfg_u_t;

    typedef struct packed {
        int unsigned nlineWidth;
        mpc_cfg_u_t  u;
    } mpc_cfg_t;

    localparam mpc_cfg_t DefaultCfg = '{
        nlineWidth: NlineWidth,
        u: '{rfbufSize: 2, mshrNum: 4, starveLimit: 3}
    };

    typedef struct packed {
        logic   vld;
        logic   issued;
        nline_t id;
    } mshr_entry_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_ARB  = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/refill_sched_mshr.sv
// rtl/refill_sched_mshr.sv - outstanding-miss table with id match, allocation and issue selection
module refill_sched_mshr
    import refill_sched_pkg::*;
#(
    parameter int unsigned MshrNum = 4,
    parameter int unsigned CntW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  nline_t          lookup_id_i,
    output logic            hit_o,
    output logic            free_o,
    input  logic            alloc_i,
    input  logic            issue_hsk_i,
    output logic            issue_vld_o,
    output nline_t          issue_id_o,
    output logic [CntW-1:0] issued_cnt_o,
    input  logic            refill_i,
    input  nline_t          refill_id_i
);

    localparam int unsigned IdxW = clog2_min1(MshrNum);

    mshr_entry_t ent_q [MshrNum];
    mshr_entry_t ent_d [MshrNum];

    logic [IdxW-1:0] alloc_idx;
    logic [IdxW-1:0] issue_idx;
    logic            refill_match;

    // Lookup, lowest-free and lowest-unissued selection, issued count.
    always_comb begin
        hit_o        = 1'b0;
        free_o       = 1'b0;
        issue_vld_o  = 1'b0;
        alloc_idx    = '0;
        issue_idx    = '0;
        issued_cnt_o = '0;
        refill_match = 1'b0;
        for (int i = 0; i < MshrNum; i++) begin
            if (ent_q[i].vld && ent_q[i].id == lookup_id_i) hit_o = 1'b1;
            if (!ent_q[i].vld && !free_o) begin
                free_o    = 1'b1;
                alloc_idx = IdxW'(i);
            end
            if (ent_q[i].vld && !ent_q[i].issued && !issue_vld_o) begin
                issue_vld_o = 1'b1;
                issue_idx   = IdxW'(i);
            end
            if (ent_q[i].vld && ent_q[i].issued) begin
                issued_cnt_o = issued_cnt_o + CntW'(1);
                if (ent_q[i].id == refill_id_i) refill_match = 1'b1;
            end
        end
        issue_id_o = issue_vld_o ? ent_q[issue_idx].id : '0;
    end

    // Next table: retire on refill, mark issued on handshake, allocate on a new miss.
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < MshrNum; i++) begin
            if (refill_i && ent_q[i].vld && ent_q[i].issued && ent_q[i].id == refill_id_i) begin
                ent_d[i] = '0;
            end
        end
        if (issue_hsk_i && issue_vld_o) ent_d[issue_idx].issued = 1'b1;
        if (alloc_i && free_o) begin
            ent_d[alloc_idx] = '{vld: 1'b1, issued: 1'b0, id: lookup_id_i};
        end
    end

    // Table registers; reset discards every outstanding miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MshrNum; i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    // A returning refill must belong to an issued entry.
    refill_known_a: assert property (@(posedge clk) disable iff (!rst_n) refill_i |-> refill_match);

endmodule

// File: rtl/refill_sched.sv
// rtl/refill_sched.sv - miss filter, credit-limited issue and starvation-bounded refill drain
module refill_sched
    import refill_sched_pkg::*;
#(
    parameter mpc_cfg_t Cfg = DefaultCfg,
    localparam int unsigned NW     = Cfg.nlineWidth,
    localparam int unsigned RbSize = Cfg.u.rfbufSize,
    localparam int unsigned RbW    = clog2_min1(Cfg.u.rfbufSize)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [NW-1:0]     miss_id,
    output logic              miss_merged,
    output logic              memctl_req_valid,
    input  logic              memctl_req_ready,
    output logic [NW-1:0]     memctl_req_id,
    input  logic              memctl_refill_hsk,
    input  logic [NW-1:0]     memctl_refill_id,
    input  logic [RbSize-1:0] rfbuf_vld_vec,
    output logic [RbW-1:0]    rfbuf_deq_ptr,
    output logic              rfbuf_deq_ready,
    input  logic              lsq_arr_req,
    output logic              lsq_arr_gnt,
    output logic              rf_arr_we
);

    localparam int unsigned MshrNum     = Cfg.u.mshrNum;
    localparam int unsigned StarveLimit = Cfg.u.starveLimit;
    localparam int unsigned StW         = $clog2(StarveLimit + 1);
    localparam int unsigned CntW        = $clog2(MshrNum + RbSize + 1);

    logic            hit;
    logic            free_any;
    logic            issue_vld;
    nline_t          issue_id;
    logic [CntW-1:0] issued_cnt;
    logic [CntW-1:0] inflight;
    logic            credits_ok;
    logic            alloc;
    logic            issue_hsk;

    logic            rb_any;
    logic [RbW-1:0]  rb_low;

    drain_state_e    state_q, state_d;
    logic [StW-1:0]  starve_q, starve_d;

    refill_sched_mshr #(
        .MshrNum (MshrNum),
        .CntW    (CntW)
    ) u_mshr (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_id_i  (nline_t'(miss_id)),
        .hit_o        (hit),
        .free_o       (free_any),
        .alloc_i      (alloc),
        .issue_hsk_i  (issue_hsk),
        .issue_vld_o  (issue_vld),
        .issue_id_o   (issue_id),
        .issued_cnt_o (issued_cnt),
        .refill_i     (memctl_refill_hsk),
        .refill_id_i  (nline_t'(memctl_refill_id))
    );

    // In-flight lines: issued misses plus lines already parked in the refill buffer.
    always_comb begin
        inflight = issued_cnt;
        for (int i = 0; i < RbSize; i++) inflight = inflight + CntW'(rfbuf_vld_vec[i]);
    end

    assign credits_ok       = inflight < CntW'(RbSize);
    assign miss_ready       = hit | (free_any & credits_ok);
    assign miss_merged      = miss_valid & hit;
    assign alloc            = miss_valid & ~hit & free_any & credits_ok;
    assign memctl_req_valid = issue_vld & credits_ok;
    assign memctl_req_id    = memctl_req_valid ? NW'(issue_id) : '0;
    assign issue_hsk        = memctl_req_valid & memctl_req_ready;

    // Lowest valid refill-buffer entry is the drain candidate.
    always_comb begin
        rb_any = 1'b0;
        rb_low = '0;
        for (int i = 0; i < RbSize; i++) begin
            if (rfbuf_vld_vec[i] && !rb_any) begin
                rb_any = 1'b1;
                rb_low = RbW'(i);
            end
        end
    end

    // Drain decisions and array-port arbitration; LSQ keeps the port unless a write is due.
    always_comb begin
        state_d         = state_q;
        starve_d        = starve_q;
        lsq_arr_gnt     = 1'b0;
        rf_arr_we       = 1'b0;
        rfbuf_deq_ready = 1'b0;
        rfbuf_deq_ptr   = '0;
        case (state_q)
            DRAIN_IDLE: begin
                lsq_arr_gnt = lsq_arr_req;
                if (rb_any) state_d = DRAIN_ARB;
            end
            DRAIN_ARB: begin
                rfbuf_deq_ptr = rb_low;
                if (!rb_any) begin
                    state_d = DRAIN_IDLE;
                end else if (!lsq_arr_req || starve_q == StW'(StarveLimit)) begin
                    rf_arr_we       = 1'b1;
                    rfbuf_deq_ready = 1'b1;
                    starve_d        = '0;
                    state_d         = DRAIN_WAIT;
                end else begin
                    lsq_arr_gnt = 1'b1;
                    if (starve_q != StW'(StarveLimit)) starve_d = starve_q + StW'(1);
                end
            end
            DRAIN_WAIT: begin
                lsq_arr_gnt = lsq_arr_req;
                state_d     = rb_any ? DRAIN_ARB : DRAIN_IDLE;
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    // Drain FSM state and LSQ starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DRAIN_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_refill_sched.sv
// tb/tb_refill_sched.sv - self-checking bench for refill_sched against a behavioural model
module tb_refill_sched;
    import refill_sched_pkg::*;

    localparam int MN = 4;
    localparam int RB = 2;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [7:0]    miss_id = 8'h00;
    logic          miss_merged;
    logic          memctl_req_valid;
    logic          memctl_req_ready = 1'b0;
    logic [7:0]    memctl_req_id;
    logic          memctl_refill_hsk = 1'b0;
    logic [7:0]    memctl_refill_id = 8'h00;
    logic [RB-1:0] rfbuf_vld_vec = '0;
    logic [0:0]    rfbuf_deq_ptr;
    logic          rfbuf_deq_ready;
    logic          lsq_arr_req = 1'b0;
    logic          lsq_arr_gnt;
    logic          rf_arr_we;

    always #5 clk = ~clk;

    refill_sched dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_valid        (miss_valid),
        .miss_ready        (miss_ready),
        .miss_id           (miss_id),
        .miss_merged       (miss_merged),
        .memctl_req_valid  (memctl_req_valid),
        .memctl_req_ready  (memctl_req_ready),
        .memctl_req_id     (memctl_req_id),
        .memctl_refill_hsk (memctl_refill_hsk),
        .memctl_refill_id  (memctl_refill_id),
        .rfbuf_vld_vec     (rfbuf_vld_vec),
        .rfbuf_deq_ptr     (rfbuf_deq_ptr),
        .rfbuf_deq_ready   (rfbuf_deq_ready),
        .lsq_arr_req       (lsq_arr_req),
        .lsq_arr_gnt       (lsq_arr_gnt),
        .rf_arr_we         (rf_arr_we)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding misses as slots, refill buffer as bits, drain phase.
    bit            m_vld [MN];
    bit            m_iss [MN];
    logic [7:0]    m_id  [MN];
    logic [RB-1:0] m_buf;
    int            m_phase;   // 0 idle, 1 arbitrate, 2 write recovery
    int            m_starve;
    int            obs_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < MN; i++) begin
            m_vld[i] = 1'b0;
            m_iss[i] = 1'b0;
            m_id[i]  = 8'h00;
        end
        m_buf    = '0;
        m_phase  = 0;
        m_starve = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miss_ready"},  32'(miss_ready),       32'd1);
        chk({tag, "_miss_merged"}, 32'(miss_merged),      32'd0);
        chk({tag, "_req_valid"},   32'(memctl_req_valid), 32'd0);
        chk({tag, "_req_id"},      32'(memctl_req_id),    32'd0);
        chk({tag, "_deq_ptr"},     32'(rfbuf_deq_ptr),    32'd0);
        chk({tag, "_deq_ready"},   32'(rfbuf_deq_ready),  32'd0);
        chk({tag, "_lsq_gnt"},     32'(lsq_arr_gnt),      32'd0);
        chk({tag, "_arr_we"},      32'(rf_arr_we),        32'd0);
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic mv, input logic [7:0] mid, input logic mrdy,
                        input logic rhsk, input logic [7:0] rid, input logic lreq);
        bit            hit, ok, e_rdy, e_mrg, e_req, e_gnt, e_we, e_deq, placed;
        int            fidx, iidx, icnt, e_ptr, nphase;
        logic [7:0]    e_id;
        logic [RB-1:0] nbuf;
        @(negedge clk);
        miss_valid        = mv;
        miss_id           = mid;
        memctl_req_ready  = mrdy;
        memctl_refill_hsk = rhsk;
        memctl_refill_id  = rid;
        lsq_arr_req       = lreq;
        rfbuf_vld_vec     = m_buf;

        hit = 1'b0; fidx = -1; iidx = -1; icnt = 0;
        for (int i = 0; i < MN; i++) begin
            if (m_vld[i] && m_id[i] == mid) hit = 1'b1;
            if (!m_vld[i] && fidx < 0) fidx = i;
            if (m_vld[i] && !m_iss[i] && iidx < 0) iidx = i;
            if (m_vld[i] && m_iss[i]) icnt++;
        end
        ok    = (icnt + $countones(m_buf)) < RB;
        e_rdy = hit || (fidx >= 0 && ok);
        e_mrg = mv && hit;
        e_req = (iidx >= 0) && ok;
        e_id  = e_req ? m_id[iidx] : 8'h00;

        e_gnt = 1'b0; e_we = 1'b0; e_deq = 1'b0; e_ptr = 0; nphase = m_phase;
        for (int i = RB - 1; i >= 0; i--) if (m_buf[i]) e_ptr = i;
        if (m_phase == 0) begin
            e_gnt = lreq; e_ptr = 0;
            nphase = (m_buf != 0) ? 1 : 0;
        end else if (m_phase == 1) begin
            if (!lreq || m_starve == SL) begin
                e_we = 1'b1; e_deq = 1'b1; m_starve = 0; nphase = 2;
            end else begin
                e_gnt = 1'b1;
                m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            end
        end else begin
            e_gnt = lreq; e_ptr = 0;
            nphase = (m_buf != 0) ? 1 : 0;
        end

        #1;
        chk("miss_ready",   32'(miss_ready),                32'(e_rdy));
        chk("miss_merged",  32'(miss_merged),               32'(e_mrg));
        chk("req_valid",    32'(memctl_req_valid),          32'(e_req));
        chk("req_id",       32'(memctl_req_id),             32'(e_id));
        chk("lsq_gnt",      32'(lsq_arr_gnt),               32'(e_gnt));
        chk("arr_we",       32'(rf_arr_we),                 32'(e_we));
        chk("deq_ready",    32'(rfbuf_deq_ready),           32'(e_deq));
        chk("deq_ptr",      32'(rfbuf_deq_ptr),             32'(e_ptr));
        chk("gnt_we_excl",  32'(lsq_arr_gnt & rf_arr_we),   32'd0);
        if (memctl_req_valid === 1'b1 && mrdy) obs_issue++;

        if (rhsk) begin
            for (int i = 0; i < MN; i++)
                if (m_vld[i] && m_iss[i] && m_id[i] == rid) begin
                    m_vld[i] = 1'b0; m_iss[i] = 1'b0;
                end
        end
        if (e_req && mrdy) m_iss[iidx] = 1'b1;
        if (mv && !hit && fidx >= 0 && ok) begin
            m_vld[fidx] = 1'b1; m_iss[fidx] = 1'b0; m_id[fidx] = mid;
        end
        nbuf = m_buf;
        if (e_deq) nbuf[e_ptr] = 1'b0;
        if (rhsk) begin
            placed = 1'b0;
            for (int i = 0; i < RB; i++)
                if (!m_buf[i] && !placed) begin
                    nbuf[i] = 1'b1; placed = 1'b1;
                end
        end
        m_buf   = nbuf;
        m_phase = nphase;
    endtask

    // Return everything outstanding and let the buffer empty, with a cycle bound.
    task automatic drain_all(input string tag);
        int         guard;
        bit         busy, rh;
        logic [7:0] rid;
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 80) begin
            rh = 1'b0; rid = 8'h00;
            for (int i = MN - 1; i >= 0; i--)
                if (m_vld[i] && m_iss[i]) begin rh = 1'b1; rid = m_id[i]; end
            step(1'b0, 8'h00, 1'b1, rh, rid, 1'b0);
            guard++;
            busy = (m_buf != 0) || (m_phase != 0);
            for (int i = 0; i < MN; i++) if (m_vld[i]) busy = 1'b1;
        end
        chk({tag, "_drain_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        obs_issue = 0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single miss: issue next cycle, refill, one-cycle drain write then recovery.
        step(1'b1, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("single_accept", 32'(miss_ready), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("single_req_valid", 32'(memctl_req_valid), 32'd1);
        chk("single_req_id",    32'(memctl_req_id),    32'h15);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h15, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("single_we",  32'(rf_arr_we), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("single_wait_we", 32'(rf_arr_we), 32'd0);
        drain_all("single");

        // Duplicate one cycle apart: merged, exactly one issue.
        obs_issue = 0;
        step(1'b1, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("dup_merged", 32'(miss_merged), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("dup_one_issue", 32'(obs_issue), 32'd1);
        drain_all("dup");

        // Credit limit: one buffered line plus misses allows a single issue.
        obs_issue = 0;
        m_buf = 2'b01;
        step(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("credit_block_ready", 32'(miss_ready), 32'd0);
        step(1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("credit_one_issue", 32'(obs_issue), 32'd1);
        step(1'b1, 8'h23, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("credit_resume_issue", 32'(obs_issue), 32'd2);
        drain_all("credit");

        // Table full: fifth distinct id refused, duplicate of an outstanding id merged.
        step(1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h35, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_ready", 32'(miss_ready), 32'd0);
        step(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_dup_ready",  32'(miss_ready),  32'd1);
        chk("full_dup_merged", 32'(miss_merged), 32'd1);
        drain_all("full");

        // Starvation: three LSQ grants in arbitration, then a forced refill write.
        m_buf = 2'b10;
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("starve_g1", 32'(lsq_arr_gnt), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("starve_g2", 32'(lsq_arr_gnt), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("starve_g3", 32'(lsq_arr_gnt), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("starve_we",      32'(rf_arr_we),     32'd1);
        chk("starve_ptr",     32'(rfbuf_deq_ptr), 32'd1);
        chk("starve_gnt_off", 32'(lsq_arr_gnt),   32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("wait_gnt", 32'(lsq_arr_gnt), 32'd1);
        m_buf = 2'b01;
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("starve_cleared", 32'(lsq_arr_gnt), 32'd1);
        drain_all("starve");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            int         q[$];
            bit         rh;
            logic [7:0] rid;
            q = {};
            for (int i = 0; i < MN; i++) if (m_vld[i] && m_iss[i]) q.push_back(i);
            rh  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            rid = rh ? m_id[q[$urandom_range(0, q.size() - 1)]] : 8'h00;
            step(1'($urandom_range(0, 1)), 8'h10 + 8'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) != 0), rh, rid, ($urandom_range(0, 2) != 0));
        end
        drain_all("random");

        // Asynchronous reset with two outstanding misses.
        step(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #2;
        rst_n             = 1'b0;
        miss_valid        = 1'b0;
        miss_id           = 8'h00;
        memctl_req_ready  = 1'b0;
        memctl_refill_hsk = 1'b0;
        memctl_refill_id  = 8'h00;
        lsq_arr_req       = 1'b0;
        rfbuf_vld_vec     = '0;
        reset_model();
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_reset_merged", 32'(miss_merged), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_reset_req_valid", 32'(memctl_req_valid), 32'd1);
        chk("post_reset_req_id",    32'(memctl_req_id),    32'h41);
        drain_all("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
